pixel_stream_tx: RTL and testbench
==================================

Name: pixel_stream_tx

Overview:
Raster pixel-stream transmitter that feeds the enhancement pipeline's valid/data input. It accepts 24-bit RGB pixels from an upstream valid/ready source and buffers them in an internal FIFO. It emits them as WIDTH x HEIGHT frames with programmable horizontal and vertical blanking, plus start-of-frame and end-of-line markers. The downstream consumer has no backpressure, so this block owns all pacing and reports underruns.

Parameters:
WIDTH, 1920, active pixels per line (>=2)
HEIGHT, 1080, active lines per frame (>=1)
HBLANK, 280, idle cycles after each non-final line (>=1)
VBLANK, 45, idle cycles after the final line of a frame (>=1)
FIFO_DEPTH, 64, internal FIFO entries, power of 2
START_LEVEL, 32, FIFO occupancy required before a line may start (1..FIFO_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
enable  in  1  permit new frames; sampled only in IDLE
in_valid  in  1  upstream pixel valid
in_ready  out  1  FIFO can accept a pixel
in_data  in  24  upstream pixel {R,G,B}
dst_valid  out  1  output pixel valid
dst_data  out  24  output pixel
dst_sof  out  1  high with the first pixel of a frame
dst_eol  out  1  high with the last pixel of each line
underrun  out  1  sticky: FIFO empty while a line is active
clear_err  in  1  clears underrun
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO flushed (level 0); state IDLE; x=0, y=0, blank counter=0.
- FIFO:
  - in_ready = (level != FIFO_DEPTH).
  - Write when in_valid && in_ready. Read when rd_en (defined below).
  - Simultaneous write and read: level unchanged; order preserved.
  - A write to an empty FIFO is readable no earlier than the next cycle.
- Line-start condition: level >= START_LEVEL, or level == FIFO_DEPTH.
- State machine:
  - IDLE:
    - x=0, y=0.
    - Go to ACTIVE when enable && line-start condition.
  - ACTIVE:
    - rd_en = FIFO not empty.
    - On each read: x++.
    - Read with x==WIDTH-1:
      - x becomes 0.
      - If y<HEIGHT-1: go to HBLANK.
      - Otherwise: go to VBLANK and y becomes 0.
    - FIFO empty in ACTIVE: no read, x holds, underrun <= 1 (the line stalls; no pixel is dropped or repeated).
  - HBLANK:
    - Count HBLANK cycles.
    - Afterwards, y++. Go to ACTIVE when the line-start condition holds; otherwise wait in HBLANK. Waiting does not set underrun.
  - VBLANK:
    - Count VBLANK cycles, then go to IDLE.
- Output register, 1-cycle latency from read:
  - dst_valid <= rd_en.
  - dst_data <= FIFO head, or hold when not reading.
  - dst_sof <= rd_en && x==0 && y==0.
  - dst_eol <= rd_en && x==WIDTH-1.
- enable deasserted mid-frame: the current frame completes, including VBLANK. The block then stays in IDLE. Upstream may continue filling the FIFO.
- underrun: set has priority over clear_err in the same cycle. It is cleared only by clear_err or reset.
- Counters: x width $clog2(WIDTH), y width $clog2(HEIGHT), blank counter sized to max(HBLANK,VBLANK). No wrap beyond the stated terminal values.
- Outputs dst_* are registered. No combinational path from in_valid to dst_*. in_ready depends only on registered level.

Test Plan:
- WIDTH=4, HEIGHT=2, HBLANK=2, VBLANK=3, FIFO_DEPTH=8, START_LEVEL=4, enable=1; burst 8 pixels 0x000001..0x000008 -> dst_valid for 4 consecutive cycles with data 1..4, dst_sof with 1, dst_eol with 4; exactly 2 idle cycles; then 5..8 with dst_eol on 8 and sof low; next frame no earlier than 3 cycles later.
- Same params, enable=1, in_valid held high with pixels, enable pulsed low before start (block stays IDLE) -> level reaches 8, in_ready=0, no dst_valid; enable=1 -> output starts; in_ready=1 the cycle after the first read.
- Feed 4 pixels, then a 5-cycle gap, then the rest -> line 1 outputs pixels 1..4. Line 2 waits in HBLANK until level>=4, dst_valid has no gaps inside lines, underrun stays 0.
- START_LEVEL=1: feed 1 pixel, stall 3 cycles, feed 3 -> dst_valid low for the stall cycles mid-line, underrun=1, pixel order intact. clear_err=1 -> underrun=0 next cycle; clear_err coincident with another empty-in-ACTIVE cycle -> underrun stays 1.
- Deassert enable after the first pixel of a frame -> the full 8-pixel frame plus VBLANK completes, then no further dst_valid while enable=0.
- Assert rst_n=0 mid-line -> all outputs 0 immediately (asynchronous), level=0. After release, the next frame begins with dst_sof on its first pixel.

Source files
------------

// File: rtl/pixel_stream_tx.sv
// Raster pixel-stream transmitter: buffers upstream RGB pixels in a FIFO and paces them
// out as WIDTH x HEIGHT frames with horizontal/vertical blanking, SOF/EOL markers and underrun flag.
module pixel_stream_tx #(
  parameter int WIDTH       = 1920,
  parameter int HEIGHT      = 1080,
  parameter int HBLANK      = 280,
  parameter int VBLANK      = 45,
  parameter int FIFO_DEPTH  = 64,
  parameter int START_LEVEL = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [23:0]                   in_data,
  output logic                          dst_valid,
  output logic [23:0]                   dst_data,
  output logic                          dst_sof,
  output logic                          dst_eol,
  output logic                          underrun,
  input  logic                          clear_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [XW-1:0] X_LAST      = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(HEIGHT - 1);
  localparam logic [BW-1:0] H_LAST      = BW'(HBLANK - 1);
  localparam logic [BW-1:0] V_LAST      = BW'(VBLANK - 1);
  localparam logic [AW-1:0] PTR_LAST    = AW'(FIFO_DEPTH - 1);
  localparam logic [LW-1:0] LEVEL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LEVEL_START = LW'(START_LEVEL);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_e;

  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [BW-1:0] blank_q, blank_d;

  logic          dst_valid_q, dst_sof_q, dst_eol_q, underrun_q;
  logic [23:0]   dst_data_q;

  logic          wr_en, rd_en, fifo_empty, line_start, set_err;

  assign in_ready   = (level_q != LEVEL_FULL);
  assign fifo_empty = (level_q == '0);
  assign wr_en      = in_valid && in_ready;
  assign line_start = (level_q >= LEVEL_START) || (level_q == LEVEL_FULL);
  assign fifo_level = level_q;

  // NOTE: the storage array is deliberately not reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  // NOTE: sequential state is only ever assigned with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      blank_q <= blank_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    blank_d = blank_q;
    rd_en   = 1'b0;
    set_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        x_d     = '0;
        y_d     = '0;
        blank_d = '0;
        if (enable && line_start) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        // An empty FIFO stalls the line in place rather than dropping or repeating a pixel.
        if (fifo_empty) begin
          set_err = 1'b1;
        end else begin
          rd_en = 1'b1;
          if (x_q == X_LAST) begin
            x_d     = '0;
            blank_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = S_VBLANK;
            end else begin
              state_d = S_HBLANK;
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_HBLANK: begin
        // Counter saturates at its terminal value while waiting for enough buffered pixels.
        if (blank_q != H_LAST) begin
          blank_d = blank_q + BW'(1);
        end else if (line_start) begin
          blank_d = '0;
          y_d     = y_q + YW'(1);
          state_d = S_ACTIVE;
        end
      end
      S_VBLANK: begin
        if (blank_q != V_LAST) begin
          blank_d = blank_q + BW'(1);
        end else begin
          blank_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_valid_q <= 1'b0;
      dst_data_q  <= '0;
      dst_sof_q   <= 1'b0;
      dst_eol_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      dst_valid_q <= rd_en;
      if (rd_en) dst_data_q <= mem_q[rd_ptr_q];
      dst_sof_q   <= rd_en && (x_q == '0) && (y_q == '0);
      dst_eol_q   <= rd_en && (x_q == X_LAST);
      if (set_err)        underrun_q <= 1'b1;
      else if (clear_err) underrun_q <= 1'b0;
    end
  end

  assign dst_valid = dst_valid_q;
  assign dst_data  = dst_data_q;
  assign dst_sof   = dst_sof_q;
  assign dst_eol   = dst_eol_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Self-checking bench for pixel_stream_tx: scoreboard of accepted pixels versus emitted stream,
// plus timing checks on line/blanking spacing, enable gating, underrun and async reset.
module tb_pixel_stream_tx;

  localparam int W = 4, H = 2, HB = 2, VB = 3, DEPTH = 8;
  localparam int LW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en [2], iv [2], ce [2], ir [2], dv [2], sof [2], eol [2], ur [2];
  logic [23:0] id [2], dd [2];
  logic [LW-1:0] lvl [2];

  int total = 0, bad = 0;
  int cyc = 0;
  logic [23:0] sb [2][$];
  int vcyc [2][$];
  int idx [2];

  always #5 clk = ~clk;

  pixel_stream_tx #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VBLANK(VB),
                    .FIFO_DEPTH(DEPTH), .START_LEVEL(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .dst_valid(dv[0]), .dst_data(dd[0]), .dst_sof(sof[0]),
    .dst_eol(eol[0]), .underrun(ur[0]), .clear_err(ce[0]), .fifo_level(lvl[0]));

  pixel_stream_tx #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VBLANK(VB),
                    .FIFO_DEPTH(DEPTH), .START_LEVEL(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .dst_valid(dv[1]), .dst_data(dd[1]), .dst_sof(sof[1]),
    .dst_eol(eol[1]), .underrun(ur[1]), .clear_err(ce[1]), .fifo_level(lvl[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accepted pixels are queued at the negedge before the write edge; outputs are popped at negedges.
  always @(negedge clk) begin : monitor
    logic [23:0] e;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        sb[k].delete();
        vcyc[k].delete();
        idx[k] = 0;
      end else begin
        if (dv[k]) begin
          vcyc[k].push_back(cyc);
          if (sb[k].size() == 0) begin
            check($sformatf("d%0d_unexpected_valid", k), 32'(dv[k]), 32'd0);
          end else begin
            e = sb[k].pop_front();
            check($sformatf("d%0d_data", k), 32'(dd[k]), 32'(e));
            check($sformatf("d%0d_sof", k), 32'(sof[k]), 32'(idx[k] == 0));
            check($sformatf("d%0d_eol", k), 32'(eol[k]), 32'((idx[k] % W) == W - 1));
            idx[k] = (idx[k] + 1) % (W * H);
          end
        end else begin
          check($sformatf("d%0d_idle_marks", k), 32'({sof[k], eol[k]}), 32'd0);
        end
        if (iv[k] && ir[k]) sb[k].push_back(id[k]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; iv[k] = 1'b0; ce[k] = 1'b0; id[k] = '0;
    end
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic send(input int k, input logic [23:0] d);
    int n;
    iv[k] = 1'b1;
    id[k] = d;
    n = 0;
    while (!ir[k] && n < 200) begin
      tick(1);
      n++;
    end
    if (!ir[k]) check("send_timeout", 32'(ir[k]), 32'd1);
    tick(1);
    iv[k] = 1'b0;
  endtask

  task automatic send_range(input int k, input int first, input int last);
    for (int v = first; v <= last; v++) send(k, 24'(v));
  endtask

  task automatic wait_out(input int k, input int n, input int budget);
    int c;
    c = 0;
    while (vcyc[k].size() < n && c < budget) begin
      tick(1);
      c++;
    end
    if (vcyc[k].size() < n) check("wait_out_timeout", 32'(vcyc[k].size()), 32'(n));
  endtask

  function automatic int gap(input int k, input int a, input int b);
    if (b >= vcyc[k].size()) return -1;
    return vcyc[k][b] - vcyc[k][a];
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; iv[k] = 1'b0; ce[k] = 1'b0; id[k] = '0;
    end
    do_reset();

    check("rst_valid", 32'(dv[0]), 32'd0);
    check("rst_data", 32'(dd[0]), 32'd0);
    check("rst_marks", 32'({sof[0], eol[0]}), 32'd0);
    check("rst_underrun", 32'(ur[0]), 32'd0);
    check("rst_level", 32'(lvl[0]), 32'd0);
    check("rst_in_ready", 32'(ir[0]), 32'd1);

    // Two back-to-back frames: line spacing, HBLANK gap and VBLANK + IDLE gap.
    en[0] = 1'b1;
    send_range(0, 1, 16);
    wait_out(0, 16, 200);
    tick(10);
    check("t1_count", 32'(vcyc[0].size()), 32'd16);
    check("t1_line1", 32'(gap(0, 0, 3)), 32'd3);
    check("t1_hblank", 32'(gap(0, 3, 4)), 32'(HB + 1));
    check("t1_line2", 32'(gap(0, 4, 7)), 32'd3);
    check("t1_vblank", 32'(gap(0, 7, 8)), 32'(VB + 2));
    check("t1_underrun", 32'(ur[0]), 32'd0);

    // Fill to full with enable low, then release enable with a pixel waiting on in_ready.
    do_reset();
    en[0] = 1'b1;
    tick(1);
    en[0] = 1'b0;
    send_range(0, 1, 8);
    tick(3);
    check("t2_level", 32'(lvl[0]), 32'(DEPTH));
    check("t2_in_ready", 32'(ir[0]), 32'd0);
    check("t2_no_out", 32'(vcyc[0].size()), 32'd0);
    iv[0] = 1'b1;
    id[0] = 24'd9;
    en[0] = 1'b1;
    n = 0;
    while (!ir[0] && n < 20) begin
      tick(1);
      n++;
    end
    check("t2_ready_latency", 32'(n), 32'd2);
    check("t2_first_valid", 32'(dv[0]), 32'd1);
    tick(1);
    iv[0] = 1'b0;
    send_range(0, 10, 16);
    wait_out(0, 16, 300);
    tick(10);
    check("t2_count", 32'(vcyc[0].size()), 32'd16);
    check("t2_underrun", 32'(ur[0]), 32'd0);

    // Upstream gap between lines: second line waits in HBLANK, no gaps inside lines.
    do_reset();
    en[0] = 1'b1;
    send_range(0, 1, 4);
    tick(5);
    send_range(0, 5, 8);
    wait_out(0, 8, 200);
    tick(10);
    check("t3_count", 32'(vcyc[0].size()), 32'd8);
    check("t3_line1", 32'(gap(0, 0, 3)), 32'd3);
    check("t3_line2", 32'(gap(0, 4, 7)), 32'd3);
    check("t3_hblank_wait", 32'(gap(0, 3, 4) > HB + 1), 32'd1);
    check("t3_underrun", 32'(ur[0]), 32'd0);

    // START_LEVEL=1: mid-line stall raises underrun; set beats clear.
    do_reset();
    en[1] = 1'b1;
    send(1, 24'd1);
    tick(3);
    send_range(1, 2, 4);
    wait_out(1, 4, 100);
    check("t4_stall_gap", 32'(gap(1, 0, 1)), 32'd3);
    check("t4_resume", 32'(gap(1, 1, 3)), 32'd2);
    check("t4_underrun_set", 32'(ur[1]), 32'd1);
    send_range(1, 5, 8);
    wait_out(1, 8, 100);
    tick(10);
    ce[1] = 1'b1;
    tick(1);
    ce[1] = 1'b0;
    check("t4_clear", 32'(ur[1]), 32'd0);
    send(1, 24'd9);
    tick(2);
    ce[1] = 1'b1;
    tick(1);
    ce[1] = 1'b0;
    check("t4_set_wins", 32'(ur[1]), 32'd1);
    send_range(1, 10, 16);
    wait_out(1, 16, 200);
    tick(10);
    check("t4_count", 32'(vcyc[1].size()), 32'd16);
    check("t4_sticky", 32'(ur[1]), 32'd1);

    // Enable dropped after the first pixel: frame finishes, no next frame, FIFO keeps filling.
    do_reset();
    en[0] = 1'b1;
    fork
      send_range(0, 1, 12);
      begin
        wait_out(0, 1, 100);
        en[0] = 1'b0;
      end
    join
    wait_out(0, 8, 200);
    tick(30);
    check("t5_count", 32'(vcyc[0].size()), 32'd8);
    check("t5_level", 32'(lvl[0]), 32'd4);
    check("t5_underrun", 32'(ur[0]), 32'd0);

    // Asynchronous reset mid-line, then a clean frame starting with SOF.
    do_reset();
    en[0] = 1'b1;
    send_range(0, 1, 6);
    check("t6_pre_valid", 32'(dv[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(dv[0]), 32'd0);
    check("t6_async_data", 32'(dd[0]), 32'd0);
    check("t6_async_marks", 32'({sof[0], eol[0]}), 32'd0);
    check("t6_async_level", 32'(lvl[0]), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    en[0] = 1'b1;
    send_range(0, 21, 28);
    wait_out(0, 8, 200);
    tick(10);
    check("t6_count", 32'(vcyc[0].size()), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
